// File: rtl/pong_frame_ctrl_if.sv
// rtl/pong_frame_ctrl_if.sv - Pong frame controller bundle: frame tick, buttons in; object positions, scores, status out
interface pong_frame_ctrl_if;
  logic       frame_tick;
  logic       serve;
  logic       l_up;
  logic       l_dn;
  logic       r_up;
  logic       r_dn;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       busy;

  modport master (
    output frame_tick, serve, l_up, l_dn, r_up, r_dn,
    input  ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_over, busy
  );

  modport slave (
    input  frame_tick, serve, l_up, l_dn, r_up, r_dn,
    output ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, game_over, busy
  );
endinterface

// File: rtl/pong_frame_ctrl.sv
// rtl/pong_frame_ctrl.sv - Pong per-frame scheduler: paddle, ball, resolve sequence plus serve/play/over flow
// Optional macro PONG_SPEEDUP_EN: per-rally ball speed that grows on each paddle hit.
module pong_frame_ctrl #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BALL_SZ    = 8,
  parameter int PAD_H      = 64,
  parameter int PAD_W      = 8,
  parameter int PAD_X_L    = 16,
  parameter int PAD_X_R    = 616,
  parameter int PAD_SPEED  = 4,
  parameter int BALL_SPEED = 2,
  parameter int WIN_SCORE  = 9
) (
  input logic              clk,
  input logic              reset,
  pong_frame_ctrl_if.slave bus
);
  typedef enum logic [1:0] {G_SERVE, G_PLAY, G_OVER} game_t;
  typedef enum logic [1:0] {S_IDLE, S_PAD, S_BALL, S_RESOLVE} seq_t;

  localparam logic [9:0]         CTR_X      = 10'((H_RES - BALL_SZ) / 2);
  localparam logic [9:0]         CTR_Y      = 10'((V_RES - BALL_SZ) / 2);
  localparam logic [9:0]         PAD_Y0     = 10'((V_RES - PAD_H) / 2);
  localparam logic signed [10:0] PAD_MAX    = 11'(V_RES - PAD_H);
  localparam logic signed [10:0] PAD_STEP   = 11'(PAD_SPEED);
  localparam logic signed [10:0] BALL_Y_MAX = 11'(V_RES - BALL_SZ);
  localparam logic signed [10:0] HIT_L      = 11'(PAD_X_L + PAD_W);
  localparam logic signed [10:0] HIT_R      = 11'(PAD_X_R - BALL_SZ);
  localparam logic signed [10:0] MISS_R     = 11'(H_RES - BALL_SZ);
  localparam logic [10:0]        BALL_SZ_U  = 11'(BALL_SZ);
  localparam logic [10:0]        PAD_H_U    = 11'(PAD_H);
  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

  game_t              game;
  seq_t               seq;
  logic               dx;
  logic               dy;
  logic               serve_q;
  logic signed [10:0] nx_q;
  logic [9:0]         ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0]         score_l, score_r;
  logic               game_over, busy;
  logic signed [10:0] spd;

`ifdef PONG_SPEEDUP_EN
  localparam logic [2:0] SPD0    = 3'(BALL_SPEED);
  localparam logic [2:0] SPD_MAX = 3'd6;
  logic [2:0] speed;
  assign spd = signed'({8'd0, speed});
`else
  assign spd = 11'(BALL_SPEED);
`endif

  assign bus.ball_x    = ball_x;
  assign bus.ball_y    = ball_y;
  assign bus.pad_l_y   = pad_l_y;
  assign bus.pad_r_y   = pad_r_y;
  assign bus.score_l   = score_l;
  assign bus.score_r   = score_r;
  assign bus.game_over = game_over;
  assign bus.busy      = busy;

  function automatic logic [9:0] pad_step(input logic [9:0] y, input logic up, input logic dn);
    logic signed [10:0] t;
    t = signed'({1'b0, y});
    if (up && !dn)
      t = t - PAD_STEP;
    else if (dn && !up)
      t = t + PAD_STEP;
    if (t < 11'sd0)
      t = 11'sd0;
    else if (t > PAD_MAX)
      t = PAD_MAX;
    return t[9:0];
  endfunction

  logic signed [10:0] bx_s, by_s, nx_c, ny_c;
  logic [9:0]         ny_new;
  logic               ny_flip;
  logic               ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
  logic [3:0]         score_l_inc, score_r_inc;

  always_comb begin
    bx_s    = signed'({1'b0, ball_x});
    by_s    = signed'({1'b0, ball_y});
    nx_c    = dx ? bx_s + spd : bx_s - spd;
    ny_c    = dy ? by_s + spd : by_s - spd;
    ny_new  = ny_c[9:0];
    ny_flip = 1'b0;
    if (ny_c < 11'sd0) begin
      ny_new  = 10'd0;
      ny_flip = 1'b1;
    end else if (ny_c > BALL_Y_MAX) begin
      ny_new  = BALL_Y_MAX[9:0];
      ny_flip = 1'b1;
    end
    // ball_y already holds this frame's wall-clamped y by the time RESOLVE reads it
    ovl_l = ({1'b0, ball_y} + BALL_SZ_U > {1'b0, pad_l_y}) && ({1'b0, ball_y} < {1'b0, pad_l_y} + PAD_H_U);
    ovl_r = ({1'b0, ball_y} + BALL_SZ_U > {1'b0, pad_r_y}) && ({1'b0, ball_y} < {1'b0, pad_r_y} + PAD_H_U);
    hit_l  = !dx && (nx_q <= HIT_L) && ovl_l;
    hit_r  = dx && (nx_q >= HIT_R) && ovl_r;
    miss_l = nx_q <= 11'sd0;
    miss_r = nx_q >= MISS_R;
    score_l_inc = (score_l < WIN) ? score_l + 4'd1 : score_l;
    score_r_inc = (score_r < WIN) ? score_r + 4'd1 : score_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      game      <= G_SERVE;
      seq       <= S_IDLE;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_q   <= 1'b0;
      nx_q      <= '0;
      ball_x    <= CTR_X;
      ball_y    <= CTR_Y;
      pad_l_y   <= PAD_Y0;
      pad_r_y   <= PAD_Y0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
      busy      <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      speed     <= SPD0;
`endif
    end else begin
      case (seq)
        S_IDLE: begin
          if (bus.frame_tick) begin
            seq     <= S_PAD;
            busy    <= 1'b1;
            serve_q <= bus.serve;
          end
        end
        S_PAD: begin
          pad_l_y <= pad_step(pad_l_y, bus.l_up, bus.l_dn);
          pad_r_y <= pad_step(pad_r_y, bus.r_up, bus.r_dn);
          seq     <= S_BALL;
        end
        S_BALL: begin
          if (game == G_PLAY) begin
            ball_y <= ny_new;
            dy     <= dy ^ ny_flip;
            nx_q   <= nx_c;
          end
          seq <= S_RESOLVE;
        end
        S_RESOLVE: begin
          seq  <= S_IDLE;
          busy <= 1'b0;
          case (game)
            // a serve only changes state here, so the ball first moves on the following tick
            G_SERVE: begin
              if (serve_q)
                game <= G_PLAY;
            end
            G_OVER: begin
              if (serve_q) begin
                score_l   <= 4'd0;
                score_r   <= 4'd0;
                game_over <= 1'b0;
                game      <= G_SERVE;
`ifdef PONG_SPEEDUP_EN
                speed     <= SPD0;
`endif
              end
            end
            G_PLAY: begin
              if (hit_l || hit_r) begin
                ball_x <= hit_l ? HIT_L[9:0] : HIT_R[9:0];
                dx     <= hit_l;
`ifdef PONG_SPEEDUP_EN
                if (speed < SPD_MAX)
                  speed <= speed + 3'd1;
`endif
              end else if (miss_l || miss_r) begin
                ball_x <= CTR_X;
                ball_y <= CTR_Y;
                dx     <= miss_r;
`ifdef PONG_SPEEDUP_EN
                speed  <= SPD0;
`endif
                if (miss_l)
                  score_r <= score_r_inc;
                else
                  score_l <= score_l_inc;
                if ((miss_l ? score_r_inc : score_l_inc) == WIN) begin
                  game      <= G_OVER;
                  game_over <= 1'b1;
                end else begin
                  game <= G_SERVE;
                end
              end else begin
                ball_x <= nx_q[9:0];
              end
            end
            default: game <= G_SERVE;
          endcase
        end
        default: seq <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pong_frame_ctrl.sv
// tb/tb_pong_frame_ctrl.sv - Randomized bench for pong_frame_ctrl against an integer game model
module tb_pong_frame_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  pong_frame_ctrl_if bus();
  pong_frame_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  localparam int M_SERVE = 0, M_PLAY = 1, M_OVER = 2;
  int errors = 0;
  int checks = 0;
  int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_dx, m_dy, m_state, m_spd;
  int seq_left = 0;
  bit saw_over = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
    m_sl = 0; m_sr = 0; m_dx = 1; m_dy = 1; m_state = M_SERVE; m_spd = 2;
  endtask

  function automatic int pad_move(input int y, input bit up, input bit dn);
    int t;
    t = y;
    if (up && !dn) t = y - 4;
    if (dn && !up) t = y + 4;
    if (t < 0) t = 0;
    if (t > 416) t = 416;
    return t;
  endfunction

  function automatic bit overlaps(input int by, input int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_tick();
    int nx, ny;
    m_pl = pad_move(m_pl, bus.l_up, bus.l_dn);
    m_pr = pad_move(m_pr, bus.r_up, bus.r_dn);
    if (m_state == M_PLAY) begin
      nx = m_bx + (m_dx ? m_spd : -m_spd);
      ny = m_by + (m_dy ? m_spd : -m_spd);
      if (ny < 0) begin ny = 0; m_dy = 1 - m_dy; end
      else if (ny > 472) begin ny = 472; m_dy = 1 - m_dy; end
      m_by = ny;
      if ((m_dx == 0 && nx <= 24 && overlaps(m_by, m_pl)) || (m_dx == 1 && nx >= 608 && overlaps(m_by, m_pr))) begin
        m_bx = (m_dx == 0) ? 24 : 608;
        m_dx = 1 - m_dx;
`ifdef PONG_SPEEDUP_EN
        m_spd = (m_spd < 6) ? m_spd + 1 : 6;
`endif
      end else if (nx <= 0 || nx >= 632) begin
        if (nx <= 0) begin
          m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_dx = 0;
        end else begin
          m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_dx = 1;
        end
        m_bx = 316; m_by = 236; m_spd = 2;
        m_state = (m_sl == 9 || m_sr == 9) ? M_OVER : M_SERVE;
      end else begin
        m_bx = nx;
      end
    end else if (bus.serve) begin
      if (m_state == M_SERVE) begin
        m_state = M_PLAY;
      end else begin
        m_sl = 0; m_sr = 0; m_state = M_SERVE; m_spd = 2;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_left = 0;
      model_reset();
    end else if (seq_left > 0) begin
      seq_left--;
    end else if (bus.frame_tick) begin
      seq_left = 3;
      model_tick();
    end
  end

  always @(negedge clk) begin
    chk("busy", bus.busy, int'(seq_left > 0));
    if (seq_left == 0) begin
      chk("ball_x", bus.ball_x, m_bx);
      chk("ball_y", bus.ball_y, m_by);
      chk("pad_l_y", bus.pad_l_y, m_pl);
      chk("pad_r_y", bus.pad_r_y, m_pr);
      chk("score_l", bus.score_l, m_sl);
      chk("score_r", bus.score_r, m_sr);
      chk("game_over", bus.game_over, int'(m_state == M_OVER));
    end
  end

  task automatic set_in(input bit lu, input bit ld, input bit ru, input bit rd, input bit sv);
    bus.l_up = lu; bus.l_dn = ld; bus.r_up = ru; bus.r_dn = rd; bus.serve = sv;
  endtask

  task automatic tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit sv);
    set_in(lu, ld, ru, rd, sv);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ball_x"}, bus.ball_x, 316);
    chk({tag, "_ball_y"}, bus.ball_y, 236);
    chk({tag, "_pad_l"}, bus.pad_l_y, 208);
    chk({tag, "_pad_r"}, bus.pad_r_y, 208);
    chk({tag, "_score_l"}, bus.score_l, 0);
    chk({tag, "_score_r"}, bus.score_r, 0);
    chk({tag, "_game_over"}, bus.game_over, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int busy_cnt;
    bit lu, ld, ru, rd, sv;
    bus.frame_tick = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    #2 reset = 1'b0;
    @(negedge clk);

    for (int i = 1; i <= 60; i++) begin
      tick(1, 0, 0, 0, 0);
      if (i == 51) chk("lup_51", bus.pad_l_y, 4);
      if (i == 52) chk("lup_52", bus.pad_l_y, 0);
    end
    chk("lup_60", bus.pad_l_y, 0);
    repeat (10) tick(0, 1, 0, 0, 0);
    chk("ldn_10", bus.pad_l_y, 40);
    repeat (5) tick(1, 1, 0, 0, 0);
    chk("both_hold", bus.pad_l_y, 40);
    chk("r_pad_idle", bus.pad_r_y, 208);

    set_in(0, 0, 0, 0, 1);
    bus.frame_tick = 1'b1;
    busy_cnt = 0;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    if (bus.busy) busy_cnt++;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 3);
    for (int k = 1; k <= 158; k++) begin
      tick(0, 0, 0, 0, 0);
      if (k == 157) begin
        chk("pre_miss_x", bus.ball_x, 630);
        chk("pre_miss_y", bus.ball_y, 396);
        chk("pre_miss_sl", bus.score_l, 0);
      end
    end
    chk("miss_sl", bus.score_l, 1);
    chk("miss_x", bus.ball_x, 316);
    chk("miss_y", bus.ball_y, 236);

    tick(0, 0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0, 0);
    set_in(1, 0, 0, 1, 0);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midball");
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    tick(0, 0, 0, 0, 0);
    chk("serve_hold_x", bus.ball_x, 316);

    for (int n = 0; n < 5000; n++) begin
      lu = $urandom_range(0, 1); ld = $urandom_range(0, 1);
      ru = $urandom_range(0, 1); rd = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        lu = (m_pl + 28 > m_by); ld = !lu;
      end
      if ($urandom_range(0, 3) == 0) begin
        ru = (m_pr + 28 > m_by); rd = !ru;
      end
      sv = ($urandom_range(0, 3) == 0);
      set_in(lu, ld, ru, rd, sv);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
      end
      repeat (5) @(negedge clk);
      if (m_state == M_OVER && !saw_over) begin
        saw_over = 1;
        chk("over_flag", bus.game_over, 1);
        chk("over_win", (bus.score_l == 4'd9 || bus.score_r == 4'd9) ? 1 : 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("over_clr_l", bus.score_l, 0);
        chk("over_clr_r", bus.score_r, 0);
        chk("over_clr_go", bus.game_over, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
